// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// State encodings are fixed because they are exported on state_dbg.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_REL_CORE  = 3'd2,
    S_RUN       = 3'd3
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both stages reset to 0 so a reset always reads as "not asserted".
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Turns PLL lock into ordered core/video resets on the reference clock,
// dropping both resets at once on loss of lock and counting such losses.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_STAGGER    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_in,
  input  logic                  clr_stats,
  output logic                  rst_core,
  output logic                  rst_video,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, RELEASE_STAGGER)) + 1;
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(RELEASE_STAGGER - 1);

  logic                  lock_s;
  seq_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  loss;
  logic                  rst_core_nxt, rst_video_nxt, ready_nxt;
  logic                  lock_lost_nxt;
  logic [LOSS_CNT_W-1:0] loss_count_nxt;
  logic [LOSS_CNT_W-1:0] count_base;
  logic                  lost_base;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock_in),
    .q   (lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT_LOCK;
      cnt        <= '0;
      rst_core   <= 1'b1;
      rst_video  <= 1'b1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rst_core   <= rst_core_nxt;
      rst_video  <= rst_video_nxt;
      ready      <= ready_nxt;
      lock_lost  <= lock_lost_nxt;
      loss_count <= loss_count_nxt;
    end
  end

  // The counter is zeroed on every state change, so it never needs to wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss      = 1'b0;
    unique case (state)
      S_WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_REL_CORE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_REL_CORE: begin
        if (!lock_s) begin
          loss      = 1'b1;
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STAGGER_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          loss      = 1'b1;
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    rst_core_nxt  = !((state_nxt == S_REL_CORE) || (state_nxt == S_RUN));
    rst_video_nxt = (state_nxt != S_RUN);
    ready_nxt     = (state_nxt == S_RUN);
  end

  // A clear coinciding with a loss wipes the old value first, then counts the loss.
  always_comb begin
    count_base     = clr_stats ? '0 : loss_count;
    lost_base      = clr_stats ? 1'b0 : lock_lost;
    loss_count_nxt = count_base;
    lock_lost_nxt  = lost_base;
    if (loss) begin
      lock_lost_nxt  = 1'b1;
      loss_count_nxt = (count_base == '1) ? count_base : count_base + 1'b1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: drivers push cycle-stamped expected
// output vectors, and a negedge monitor pops and compares them in order.
module tb_pll_reset_sequencer;

  localparam int LSC = 8;
  localparam int RS  = 4;
  localparam int OW  = 15;
  localparam int W   = 32 + OW;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock_in;
  logic       clr_stats;
  logic       rst_core;
  logic       rst_video;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;
  logic [2:0] state_dbg;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LSC),
    .RELEASE_STAGGER    (RS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_in    (lock_in),
    .clr_stats  (clr_stats),
    .rst_core   (rst_core),
    .rst_video  (rst_video),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .loss_count (loss_count),
    .state_dbg  (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int unsigned  base;
  int unsigned  model_lc;
  bit           model_ll;

  // off = edge index relative to base (edge 0 = first edge after the drive)
  task automatic expect_at(input int unsigned off, input bit rc, input bit rv,
                           input bit rdy, input logic [2:0] st, input string nm);
    logic [OW-1:0] v;
    v = {rc, rv, rdy, model_ll, 8'(model_lc), st};
    exp_q.push_back({32'(base + off), v});
    name_q.push_back(nm);
  endtask

  task automatic model_loss();
    model_ll = 1'b1;
    if (model_lc < 255) model_lc = model_lc + 1;
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [OW-1:0] act;
    string         nm;
    act = {rst_core, rst_video, ready, lock_lost, loss_count, state_dbg};
    while (exp_q.size() > 0 && exp_q[0][W-1:OW] <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (e[W-1:OW] != cyc) begin
        n_err++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", nm, e[W-1:OW], cyc);
      end else if (act !== e[OW-1:0]) begin
        n_err++;
        $display("FAIL %s @%0d: got rc=%b rv=%b rdy=%b ll=%b lc=%0d st=%0d, want rc=%b rv=%b rdy=%b ll=%b lc=%0d st=%0d",
                 nm, cyc, act[14], act[13], act[12], act[11], act[10:3], act[2:0],
                 e[14], e[13], e[12], e[11], e[10:3], e[2:0]);
      end
    end
  end

  // driver tasks
  task automatic relock(input string nm);
    lock_in = 1'b1;
    base = cyc + 1;
    expect_at(9,  1, 1, 0, 3'd1, {nm, "_pre_core"});
    expect_at(10, 0, 1, 0, 3'd2, {nm, "_core"});
    expect_at(13, 0, 1, 0, 3'd2, {nm, "_pre_video"});
    expect_at(14, 0, 0, 1, 3'd3, {nm, "_run"});
    nedge(16);
  endtask

  task automatic drop_run(input string nm);
    lock_in = 1'b0;
    base = cyc + 1;
    expect_at(1, 0, 0, 1, 3'd3, {nm, "_still_run"});
    model_loss();
    expect_at(2, 1, 1, 0, 3'd0, {nm, "_loss"});
    nedge(4);
  endtask

  task automatic loss_cycle(input bit clr_at);
    lock_in = 1'b1;
    base = cyc + 1;
    expect_at(10, 0, 1, 0, 3'd2, "lc_core");
    nedge(11);
    lock_in = 1'b0;
    if (clr_at) begin
      model_lc = 0;
      model_ll = 1'b0;
    end
    model_loss();
    expect_at(13, 1, 1, 0, 3'd0, clr_at ? "clr_with_loss" : "lc_loss");
    nedge(2);
    clr_stats = clr_at;
    nedge(1);
    clr_stats = 1'b0;
    nedge(1);
  endtask

  initial begin
    rst = 1'b1;
    lock_in = 1'b0;
    clr_stats = 1'b0;
    model_lc = 0;
    model_ll = 1'b0;

    // reset and startup
    @(negedge clk);
    base = cyc + 1;
    expect_at(0, 1, 1, 0, 3'd0, "reset");
    expect_at(2, 1, 1, 0, 3'd0, "reset_hold");
    nedge(3);
    rst = 1'b0;
    lock_in = 1'b1;
    base = cyc + 1;
    expect_at(1,  1, 1, 0, 3'd0, "su_wait");
    expect_at(2,  1, 1, 0, 3'd1, "su_stable");
    expect_at(9,  1, 1, 0, 3'd1, "su_pre_core");
    expect_at(10, 0, 1, 0, 3'd2, "su_core");
    expect_at(13, 0, 1, 0, 3'd2, "su_pre_video");
    expect_at(14, 0, 0, 1, 3'd3, "su_run");
    nedge(16);

    // loss in RUN, then relock
    drop_run("run1");
    relock("relock1");

    // loss in RUN again, then loss during the stagger
    drop_run("run2");
    lock_in = 1'b1;
    base = cyc + 1;
    expect_at(10, 0, 1, 0, 3'd2, "rc_core");
    nedge(12);
    lock_in = 1'b0;
    expect_at(13, 0, 1, 0, 3'd2, "rc_pre_loss");
    model_loss();
    expect_at(14, 1, 1, 0, 3'd0, "rc_loss");
    expect_at(18, 1, 1, 0, 3'd0, "rc_no_video");
    nedge(8);

    // back to RUN with three losses recorded, then mid-operation reset
    relock("relock3");
    rst = 1'b1;
    base = cyc + 1;
    model_lc = 0;
    model_ll = 1'b0;
    expect_at(0, 1, 1, 0, 3'd0, "mid_rst");
    nedge(1);
    lock_in = 1'b0;
    nedge(1);
    rst = 1'b0;
    nedge(3);

    // acquisition glitch restarts the debounce
    lock_in = 1'b1;
    base = cyc + 1;
    expect_at(6,  1, 1, 0, 3'd1, "gl_stable");
    expect_at(7,  1, 1, 0, 3'd0, "gl_restart");
    expect_at(8,  1, 1, 0, 3'd1, "gl_stable2");
    expect_at(15, 1, 1, 0, 3'd1, "gl_hold");
    expect_at(16, 0, 1, 0, 3'd2, "gl_core");
    expect_at(20, 0, 0, 1, 3'd3, "gl_run");
    nedge(5);
    lock_in = 1'b0;
    nedge(1);
    lock_in = 1'b1;
    nedge(16);

    // saturation
    drop_run("sat_first");
    for (int i = 0; i < 260; i++) loss_cycle(1'b0);

    // clear alone, then clear coincident with a loss
    clr_stats = 1'b1;
    base = cyc + 1;
    model_lc = 0;
    model_ll = 1'b0;
    expect_at(0, 1, 1, 0, 3'd0, "clr_alone");
    nedge(1);
    clr_stats = 1'b0;
    nedge(2);
    loss_cycle(1'b1);

    nedge(5);
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: expected check never reached", name_q.pop_front());
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
